// File: rtl/aud_pkg.sv
// Shared definitions for the audio serial receive path.
//   AUD_DATA_WD        : default bits per channel sample
//   rx_state_e         : slave receiver frame FSM states
//   AUD_I2S_DELAY_*    : BCLK rising edges skipped after an LRCK edge
package aud_pkg;

    localparam int AUD_DATA_WD = 24;

    // Skipped BCLK rising edges between an LRCK edge and the MSB
    localparam int AUD_I2S_DELAY_I2S = 1;
    localparam int AUD_I2S_DELAY_LJ  = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SKIP  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } rx_state_e;

endpackage : aud_pkg

// File: rtl/aud_sync_edge.sv
// Two-flop synchronizer followed by an edge detector.
//   clk_i   : system clock
//   rst_i   : asynchronous active-high reset
//   d_i     : asynchronous input line
//   edge_o  : registered pulse, one cycle, on any change of the synchronized line
//   level_o : synchronized level after the change, aligned with edge_o
// Pin change to edge_o high takes 3 clk_i cycles.
module aud_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic edge_o,
    output logic level_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;
    logic edge_q;

    // Synchronizer stages, history register and registered edge pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            s1_q   <= d_i;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            edge_q <= s2_q ^ s3_q;
        end
    end

    // s3_q holds the post-edge level during the cycle edge_q is high
    assign edge_o  = edge_q;
    assign level_o = s3_q;

endmodule : aud_sync_edge

// File: rtl/aud_i2s_slave_rx.sv
// Serial-audio slave receiver (I2S or left-justified, selected by I2S_DELAY).
// Samples externally driven BCLK/LRCK/DATA in the clk_i domain and delivers
// stereo sample pairs.
//   clk_i       : system clock, at least 8x BCLK
//   rst_i       : asynchronous active-high reset
//   en_i        : synchronous receiver enable
//   bclk_i      : serial bit clock (async)
//   lrck_i      : channel select, 0 = left, 1 = right (async)
//   dat_i       : serial data, valid at BCLK rise (async)
//   left_o      : last complete left sample
//   right_o     : last complete right sample
//   valid_o     : one-cycle pulse when a new pair is on left_o/right_o
//   frame_err_o : one-cycle pulse when a slot ends before its word completes
//   locked_o    : receiver is frame-aligned
module aud_i2s_slave_rx
    import aud_pkg::*;
#(
    parameter int DATA_WD   = AUD_DATA_WD,
    parameter int I2S_DELAY = AUD_I2S_DELAY_I2S
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               bclk_i,
    input  logic               lrck_i,
    input  logic               dat_i,
    output logic [DATA_WD-1:0] left_o,
    output logic [DATA_WD-1:0] right_o,
    output logic               valid_o,
    output logic               frame_err_o,
    output logic               locked_o
);

    localparam int CNT_W = $clog2(DATA_WD + 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_WD - 1);
    localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'(I2S_DELAY - 1);
    localparam rx_state_e        FIRST_ST  = (I2S_DELAY == 0) ? ST_SHIFT : ST_SKIP;

    logic bclk_edge_s, bclk_lvl_s, lr_edge_s, lr_lvl_s;
    logic bclk_rise_s, lr_fall_s;

    // Data gets the same three-register depth as the bclk/lrck paths
    logic dat_s1_q, dat_s2_q, dat_s3_q;

    rx_state_e          state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               chan_q,    chan_d;
    logic [DATA_WD-1:0] shift_q,   shift_d;
    logic [DATA_WD-1:0] shadow_q,  shadow_d;
    logic               left_ok_q, left_ok_d;
    logic               locked_q,  locked_d;
    logic               valid_q,   valid_d;
    logic               ferr_q,    ferr_d;
    logic [DATA_WD-1:0] left_q,    left_d;
    logic [DATA_WD-1:0] right_q,   right_d;

    aud_sync_edge u_bclk_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .d_i     (bclk_i),
        .edge_o  (bclk_edge_s),
        .level_o (bclk_lvl_s)
    );

    aud_sync_edge u_lrck_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .d_i     (lrck_i),
        .edge_o  (lr_edge_s),
        .level_o (lr_lvl_s)
    );

    assign bclk_rise_s = bclk_edge_s & bclk_lvl_s;
    assign lr_fall_s   = lr_edge_s & ~lr_lvl_s;

    // Data synchronizer and alignment stage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dat_s1_q <= 1'b0;
            dat_s2_q <= 1'b0;
            dat_s3_q <= 1'b0;
        end else begin
            dat_s1_q <= dat_i;
            dat_s2_q <= dat_s1_q;
            dat_s3_q <= dat_s2_q;
        end
    end

    // Frame FSM: LRCK handling first, then a coincident BCLK rise counts
    // as the first edge of whatever slot LRCK just started
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        chan_d    = chan_q;
        shift_d   = shift_q;
        shadow_d  = shadow_q;
        left_ok_d = left_ok_q;
        locked_d  = locked_q;
        left_d    = left_q;
        right_d   = right_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;

        if (!en_i) begin
            state_d   = ST_IDLE;
            locked_d  = 1'b0;
            left_ok_d = 1'b0;
        end else begin
            if (lr_edge_s) begin
                if (state_q == ST_IDLE) begin
                    if (lr_fall_s) begin
                        locked_d  = 1'b1;
                        left_ok_d = 1'b0;
                        chan_d    = 1'b0;
                        cnt_d     = {CNT_W{1'b0}};
                        state_d   = FIRST_ST;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end else if (state_q != ST_HOLD) begin
                    // Slot ended before its word completed: drop alignment
                    ferr_d    = 1'b1;
                    locked_d  = 1'b0;
                    left_ok_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    chan_d    = lr_lvl_s;
                    cnt_d     = {CNT_W{1'b0}};
                    state_d   = FIRST_ST;
                    left_ok_d = lr_fall_s ? 1'b0 : left_ok_q;
                end
            end else begin
                state_d = state_q;
            end

            if (bclk_rise_s) begin
                case (state_d)
                    ST_SKIP: begin
                        if (cnt_d == SKIP_LAST) begin
                            cnt_d   = {CNT_W{1'b0}};
                            state_d = ST_SHIFT;
                        end else begin
                            cnt_d   = cnt_d + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                    ST_SHIFT: begin
                        shift_d = {shift_q[DATA_WD-2:0], dat_s3_q};
                        if (cnt_d == WORD_LAST) begin
                            cnt_d   = {CNT_W{1'b0}};
                            state_d = ST_HOLD;
                            if (!chan_d) begin
                                shadow_d  = shift_d;
                                left_ok_d = 1'b1;
                            end else if (left_ok_d) begin
                                left_d  = shadow_q;
                                right_d = shift_d;
                                valid_d = 1'b1;
                            end else begin
                                // Right word without a preceding left: no pair
                                valid_d = 1'b0;
                            end
                        end else begin
                            cnt_d = cnt_d + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                    default: begin
                        // IDLE waits for alignment, HOLD ignores padding bits
                        cnt_d = cnt_d;
                    end
                endcase
            end else begin
                shift_d = shift_q;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            chan_q    <= 1'b0;
            shift_q   <= {DATA_WD{1'b0}};
            shadow_q  <= {DATA_WD{1'b0}};
            left_ok_q <= 1'b0;
            locked_q  <= 1'b0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            left_q    <= {DATA_WD{1'b0}};
            right_q   <= {DATA_WD{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            chan_q    <= chan_d;
            shift_q   <= shift_d;
            shadow_q  <= shadow_d;
            left_ok_q <= left_ok_d;
            locked_q  <= locked_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            left_q    <= left_d;
            right_q   <= right_d;
        end
    end

    assign left_o      = left_q;
    assign right_o     = right_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign locked_o    = locked_q;

endmodule : aud_i2s_slave_rx

// File: tb/tb_aud_i2s_slave_rx.sv
// Directed bench for aud_i2s_slave_rx: one I2S instance and one
// left-justified instance share the serial lines.
module tb_aud_i2s_slave_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        bclk;
    logic        lrck;
    logic        dat;

    logic [23:0] l0, r0, l1, r1;
    logic        v0, f0, k0, v1, f1, k1;

    int checks = 0;
    int errors = 0;
    int vcnt0  = 0;
    int fcnt0  = 0;
    int vcnt1  = 0;
    int fcnt1  = 0;
    int vbase1;
    int fbase1;

    always #5 clk = ~clk;

    aud_i2s_slave_rx #(.DATA_WD(24), .I2S_DELAY(1)) u_i2s (
        .clk_i(clk), .rst_i(rst), .en_i(en), .bclk_i(bclk), .lrck_i(lrck),
        .dat_i(dat), .left_o(l0), .right_o(r0), .valid_o(v0),
        .frame_err_o(f0), .locked_o(k0)
    );

    aud_i2s_slave_rx #(.DATA_WD(24), .I2S_DELAY(0)) u_lj (
        .clk_i(clk), .rst_i(rst), .en_i(en), .bclk_i(bclk), .lrck_i(lrck),
        .dat_i(dat), .left_o(l1), .right_o(r1), .valid_o(v1),
        .frame_err_o(f1), .locked_o(k1)
    );

    // Count high cycles of the pulse outputs (a stretched pulse counts twice)
    always @(negedge clk) begin
        if (v0) vcnt0 <= vcnt0 + 1;
        if (f0) fcnt0 <= fcnt0 + 1;
        if (v1) vcnt1 <= vcnt1 + 1;
        if (f1) fcnt1 <= fcnt1 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One slot of nper BCLK periods; each period starts with BCLK falling
    // (LRCK/DATA change there) and the MSB follows dly rising edges
    task automatic send_slot(input logic lr, input logic [23:0] val, input int nper, input int dly);
        for (int k = 0; k < nper; k++) begin
            @(negedge clk);
            bclk = 1'b0;
            lrck = lr;
            if (k >= dly && (k - dly) < 24) dat = val[23 - (k - dly)];
            else                            dat = 1'b0;
            repeat (4) @(negedge clk);
            bclk = 1'b1;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [23:0] lv, input logic [23:0] rv, input int dly);
        send_slot(1'b0, lv, 32, dly);
        send_slot(1'b1, rv, 32, dly);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; bclk = 1'b0; lrck = 1'b0; dat = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_left",   {8'd0, l0}, 32'h0);
        check("rst_right",  {8'd0, r0}, 32'h0);
        check("rst_valid",  {31'd0, v0}, 32'h0);
        check("rst_ferr",   {31'd0, f0}, 32'h0);
        check("rst_locked", {31'd0, k0}, 32'h0);
        rst = 1'b0;

        // Stream begins in the middle of a right slot
        send_slot(1'b1, 24'hFEDCBA, 16, 1);
        check("mid_valid",  vcnt0, 32'd0);
        check("mid_ferr",   fcnt0, 32'd0);
        check("mid_locked", {31'd0, k0}, 32'h0);

        // First full I2S frame
        send_slot(1'b0, 24'h123456, 32, 1);
        check("f1_locked", {31'd0, k0}, 32'h1);
        send_slot(1'b1, 24'hABCDEF, 32, 1);
        check("f1_valid", vcnt0, 32'd1);
        check("f1_left",  {8'd0, l0}, 32'h123456);
        check("f1_right", {8'd0, r0}, 32'hABCDEF);
        check("f1_ferr",  fcnt0, 32'd0);

        send_frame(24'h000001, 24'hFFFFFF, 1);
        check("f2_valid", vcnt0, 32'd2);
        check("f2_left",  {8'd0, l0}, 32'h000001);
        check("f2_right", {8'd0, r0}, 32'hFFFFFF);

        // Right slot cut to 20 BCLKs; the following frame is lost
        send_slot(1'b0, 24'h111111, 32, 1);
        send_slot(1'b1, 24'h222222, 20, 1);
        send_slot(1'b0, 24'h333333, 32, 1);
        check("tr_ferr",   fcnt0, 32'd1);
        check("tr_locked", {31'd0, k0}, 32'h0);
        check("tr_left",   {8'd0, l0}, 32'h000001);
        check("tr_right",  {8'd0, r0}, 32'hFFFFFF);
        send_slot(1'b1, 24'h444444, 32, 1);
        check("tr_novalid", vcnt0, 32'd2);
        send_frame(24'h555555, 24'h666666, 1);
        check("rl_valid", vcnt0, 32'd3);
        check("rl_left",  {8'd0, l0}, 32'h555555);
        check("rl_right", {8'd0, r0}, 32'h666666);
        check("rl_ferr",  fcnt0, 32'd1);

        // Reset in the middle of a left word
        send_slot(1'b0, 24'h777777, 10, 1);
        rst = 1'b1;
        #1;
        check("mr_left",   {8'd0, l0}, 32'h0);
        check("mr_right",  {8'd0, r0}, 32'h0);
        check("mr_locked", {31'd0, k0}, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send_slot(1'b1, 24'h888888, 32, 1);
        check("mr_novalid", vcnt0, 32'd3);
        send_frame(24'h0A0B0C, 24'h0D0E0F, 1);
        check("mr_valid", vcnt0, 32'd4);
        check("mr_left2",  {8'd0, l0}, 32'h0A0B0C);
        check("mr_right2", {8'd0, r0}, 32'h0D0E0F);

        // Enable low for one frame
        @(negedge clk);
        en = 1'b0;
        send_frame(24'h121212, 24'h343434, 1);
        check("en_novalid", vcnt0, 32'd4);
        check("en_left",    {8'd0, l0}, 32'h0A0B0C);
        check("en_right",   {8'd0, r0}, 32'h0D0E0F);
        check("en_locked",  {31'd0, k0}, 32'h0);
        en = 1'b1;
        send_frame(24'h565656, 24'h787878, 1);
        check("en_valid",   vcnt0, 32'd5);
        check("en_left2",   {8'd0, l0}, 32'h565656);
        check("en_right2",  {8'd0, r0}, 32'h787878);
        check("en_locked2", {31'd0, k0}, 32'h1);
        check("en_ferr",    fcnt0, 32'd1);

        // Left-justified frame on the I2S_DELAY=0 instance
        vbase1 = vcnt1;
        fbase1 = fcnt1;
        send_frame(24'h800000, 24'h7FFFFF, 0);
        check("lj_valid", vcnt1, vbase1 + 1);
        check("lj_ferr",  fcnt1, fbase1);
        check("lj_left",  {8'd0, l1}, 32'h800000);
        check("lj_right", {8'd0, r1}, 32'h7FFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_aud_i2s_slave_rx
